// File: rtl/test_wapper.sv
// Purpose: parallel-load / serial-unload wrapper. Captures eight bytes on a begin_wr rising edge and streams them on dout, a_0 first.
// Latency: first byte appears one clock after the capture edge. outen stays high for 8 cycles, then dout/outen return to 0.
// Backpressure: none. A trigger that arrives while a stream is active or finishing is dropped, not queued.
module test_wapper #(
    parameter int DATA_W  = 8,
    parameter int N_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              begin_wr,
    input  logic [DATA_W-1:0] a_0,
    input  logic [DATA_W-1:0] a_1,
    input  logic [DATA_W-1:0] a_2,
    input  logic [DATA_W-1:0] a_3,
    input  logic [DATA_W-1:0] a_4,
    input  logic [DATA_W-1:0] a_5,
    input  logic [DATA_W-1:0] a_6,
    input  logic [DATA_W-1:0] a_7,
    output logic [DATA_W-1:0] dout,
    output logic              outen
);

    localparam int IDX_W = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               begin_q;
    logic               start;
    logic               load;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [DATA_W-1:0]  dout_nxt;
    logic               outen_nxt;
    logic [DATA_W-1:0]  a_vec    [N_WORDS];
    logic [DATA_W-1:0]  data_buf [N_WORDS];

    assign a_vec[0] = a_0;
    assign a_vec[1] = a_1;
    assign a_vec[2] = a_2;
    assign a_vec[3] = a_3;
    assign a_vec[4] = a_4;
    assign a_vec[5] = a_5;
    assign a_vec[6] = a_6;
    assign a_vec[7] = a_7;

    // A held-high begin_wr fires only once: start is the 0->1 transition.
    assign start = begin_wr & ~begin_q;

    // Next-state and registered-output values; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dout_nxt  = dout;
        outen_nxt = outen;
        load      = 1'b0;
        case (state)
            IDLE: begin
                dout_nxt  = '0;
                outen_nxt = 1'b0;
                if (start) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                dout_nxt  = data_buf[idx];
                outen_nxt = 1'b1;
                idx_nxt   = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                dout_nxt  = '0;
                outen_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                dout_nxt  = '0;
                outen_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, index, edge-detect history and output registers; reset aborts any stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            begin_q <= 1'b0;
            dout    <= '0;
            outen   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            begin_q <= begin_wr;
            dout    <= dout_nxt;
            outen   <= outen_nxt;
        end
    end

    // Snapshot all inputs in the capture cycle so later input changes cannot leak into the stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WORDS; i++) begin
                data_buf[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_WORDS; i++) begin
                data_buf[i] <= a_vec[i];
            end
        end
    end

endmodule

// File: tb/tb_test_wapper.sv
// Purpose: randomized scoreboard bench for test_wapper.
// Latency: the model queues eight bytes per accepted trigger; the monitor pops one per outen cycle.
// Backpressure: the model drops triggers that arrive inside the 10-cycle busy window after acceptance.
module tb_test_wapper;

    logic       clk;
    logic       rst_n;
    logic       begin_wr;
    logic [7:0] a [8];
    logic [7:0] dout;
    logic       outen;

    int checks;
    int failures;
    int cyc;
    int ready_cyc;
    bit prev_begin;
    bit mon_en;
    logic [7:0] exp_q [$];

    test_wapper #(.DATA_W(8), .N_WORDS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .begin_wr (begin_wr),
        .a_0      (a[0]),
        .a_1      (a[1]),
        .a_2      (a[2]),
        .a_3      (a[3]),
        .a_4      (a[4]),
        .a_5      (a[5]),
        .a_6      (a[6]),
        .a_7      (a[7]),
        .dout     (dout),
        .outen    (outen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an accepted trigger enqueues the eight bytes present at that edge
    // and blocks further triggers for the ten cycles it takes to stream and finish.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_begin = 1'b0;
            ready_cyc  = 0;
        end else begin
            if (begin_wr && !prev_begin && cyc >= ready_cyc) begin
                for (int i = 0; i < 8; i++) exp_q.push_back(a[i]);
                ready_cyc = cyc + 10;
            end
            prev_begin = begin_wr;
        end
        cyc = cyc + 1;
    end

    // Monitor: every valid byte must match the head of the scoreboard; idle cycles must show dout=0.
    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            if (outen === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: dout=%02h outen=1, no byte expected (cyc %0d)", dout, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        failures++;
                        $display("FAIL stream_byte: dout=%02h required=%02h (cyc %0d)", dout, e, cyc);
                    end
                end
            end else begin
                checks++;
                if (outen !== 1'b0 || dout !== 8'h00) begin
                    failures++;
                    $display("FAIL idle_out: outen=%b dout=%02h required outen=0 dout=00 (cyc %0d)", outen, dout, cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [7:0] base, input bit rnd);
        for (int i = 0; i < 8; i++) a[i] = rnd ? 8'($urandom) : base + 8'(i);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        ready_cyc  = 0;
        prev_begin = 1'b0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        begin_wr   = 1'b0;
        set_a(8'h00, 1'b0);

        // Reset for two cycles, then idle with begin_wr low.
        tick(1);
        mon_en = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(4);

        // Basic stream with begin_wr held high for 50 cycles: only one burst.
        set_a(8'h00, 1'b0);
        begin_wr = 1'b1;
        tick(50);
        begin_wr = 1'b0;
        drain("basic");

        // Capture isolation: inputs change right after the capture edge.
        set_a(8'h00, 1'b0);
        begin_wr = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) a[i] = 8'hFF;
        tick(12);
        begin_wr = 1'b0;
        drain("isolation");

        // Retrigger with new data.
        set_a(8'h10, 1'b0);
        begin_wr = 1'b1;
        tick(12);
        begin_wr = 1'b0;
        drain("retrigger");

        // Ignored trigger: low/high pulse during SEND.
        set_a(8'h20, 1'b0);
        begin_wr = 1'b1;
        tick(3);
        begin_wr = 1'b0;
        tick(1);
        begin_wr = 1'b1;
        tick(14);
        begin_wr = 1'b0;
        drain("ignored");

        // Mid-stream reset at the 4th byte; nothing resumes afterwards.
        set_a(8'h30, 1'b0);
        begin_wr = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n    = 1'b1;
        begin_wr = 1'b0;
        tick(15);
        drain("midreset");

        // Randomized triggers, gaps and in-burst pulses.
        for (int it = 0; it < 30; it++) begin
            set_a(8'h00, 1'b1);
            begin_wr = 1'b1;
            tick($urandom_range(1, 12));
            if ($urandom_range(0, 3) == 0) begin
                begin_wr = 1'b0;
                tick(1);
                begin_wr = 1'b1;
                tick($urandom_range(1, 4));
            end
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            set_a(8'h00, 1'b1);
            begin_wr = 1'b0;
            tick($urandom_range(1, 8));
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

endmodule
